// File: rtl/pcm_sample_fifo.sv
// pcm_sample_fifo: PCM sample buffer with strobe/edge requests, watermarks, flush and sticky error flags.
module pcm_sample_fifo #(
    parameter int ABITS     = 6,
    parameter int DBITS     = 8,
    parameter int EDGE_MODE = 1,
    parameter int AF_LEVEL  = 2**ABITS-4,
    parameter int AE_LEVEL  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rd,
    input  logic             wr,
    input  logic             flush,
    input  logic [DBITS-1:0] din,
    output logic [DBITS-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic [ABITS:0]   level,
    output logic             overflow,
    output logic             underflow
);
    localparam int DEPTH = 2**ABITS;
    logic [DBITS-1:0] mem [DEPTH];
    logic [ABITS-1:0] rd_ptr, wr_ptr;
    logic [ABITS:0]   level_nxt;
    logic             rd_req, wr_req, do_rd, do_wr;

    generate
        if (EDGE_MODE != 0) begin : g_edge
            // bit 0 is d1, bit 1 is d2; a request fires for one cycle after a falling edge
            logic [1:0] rd_d, wr_d;
            always_ff @(posedge clock or posedge reset)
                if (reset) begin
                    rd_d <= '0;
                    wr_d <= '0;
                end else begin
                    rd_d <= {rd_d[0], rd};
                    wr_d <= {wr_d[0], wr};
                end
            assign rd_req = ~rd_d[0] & rd_d[1];
            assign wr_req = ~wr_d[0] & wr_d[1];
        end else begin : g_strobe
            assign rd_req = rd;
            assign wr_req = wr;
        end
    endgenerate

    // a write into a full buffer proceeds only when a read frees the slot in the same edge
    always_comb begin
        do_wr     = ~flush & wr_req & (~full | rd_req);
        do_rd     = ~flush & rd_req & ~empty;
        level_nxt = flush ? '0 : level + {{ABITS{1'b0}}, do_wr} - {{ABITS{1'b0}}, do_rd};
    end

    always_ff @(posedge clock)
        if (do_wr)
            mem[wr_ptr] <= din;

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            level        <= '0;
            dout         <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= (AF_LEVEL == 0);
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            rd_ptr       <= flush ? '0 : rd_ptr + ABITS'(do_rd);
            wr_ptr       <= flush ? '0 : wr_ptr + ABITS'(do_wr);
            level        <= level_nxt;
            dout         <= do_rd ? mem[rd_ptr] : dout;
            empty        <= level_nxt == '0;
            full         <= level_nxt == (ABITS+1)'(DEPTH);
            almost_empty <= level_nxt <= (ABITS+1)'(AE_LEVEL);
            almost_full  <= level_nxt >= (ABITS+1)'(AF_LEVEL);
            overflow     <= ~flush & (overflow | (wr_req & full & ~rd_req));
            underflow    <= ~flush & (underflow | (rd_req & empty));
        end
endmodule

// File: tb/tb_pcm_sample_fifo.sv
// tb_pcm_sample_fifo: directed checks of pcm_sample_fifo in strobe mode (u0) and edge mode (u1), ABITS=2.
module tb_pcm_sample_fifo;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rd0 = 1'b0, wr0 = 1'b0, flush0 = 1'b0;
    logic       rd1 = 1'b0, wr1 = 1'b0;
    logic [7:0] din0 = '0, din1 = '0;
    logic [7:0] dout0, dout1;
    logic [2:0] level0, level1;
    logic       empty0, full0, ae0, af0, ovf0, unf0;
    logic       empty1, full1, ae1, af1, ovf1, unf1;
    int         total = 0, bad = 0;

    always #5 clock = ~clock;

    pcm_sample_fifo #(.ABITS(2), .DBITS(8), .EDGE_MODE(0), .AF_LEVEL(3), .AE_LEVEL(1)) u0 (
        .clock(clock), .reset(reset), .rd(rd0), .wr(wr0), .flush(flush0), .din(din0),
        .dout(dout0), .empty(empty0), .full(full0), .almost_empty(ae0), .almost_full(af0),
        .level(level0), .overflow(ovf0), .underflow(unf0));

    pcm_sample_fifo #(.ABITS(2), .DBITS(8), .EDGE_MODE(1), .AF_LEVEL(3), .AE_LEVEL(1)) u1 (
        .clock(clock), .reset(reset), .rd(rd1), .wr(wr1), .flush(1'b0), .din(din1),
        .dout(dout1), .empty(empty1), .full(full1), .almost_empty(ae1), .almost_full(af1),
        .level(level1), .overflow(ovf1), .underflow(unf1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // one strobe-mode operation at the next rising edge; returns 1 time unit after it
    task automatic step0(input logic r, input logic w, input logic f, input logic [7:0] d);
        rd0 = r;
        wr0 = w;
        flush0 = f;
        din0 = d;
        @(posedge clock);
        #1;
        rd0 = 1'b0;
        wr0 = 1'b0;
        flush0 = 1'b0;
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        chk("rst_level", level0, 0);
        chk("rst_empty", empty0, 1);
        chk("rst_full", full0, 0);
        chk("rst_ae", ae0, 1);
        chk("rst_af", af0, 0);
        chk("rst_flags", {ovf0, unf0}, 0);
        chk("rst_dout", dout0, 0);
        chk("rst_level_e", level1, 0);

        step0(0, 1, 0, 8'h11);
        chk("w1_level", level0, 1);
        chk("w1_ae", ae0, 1);
        step0(0, 1, 0, 8'h22);
        chk("w2_ae", ae0, 0);
        step0(0, 1, 0, 8'h33);
        chk("w3_af", af0, 1);
        chk("w3_full", full0, 0);
        step0(0, 1, 0, 8'h44);
        chk("w4_full", full0, 1);
        chk("w4_level", level0, 4);
        chk("w4_ovf", ovf0, 0);
        step0(0, 1, 0, 8'h55);
        chk("ovf_set", ovf0, 1);
        chk("ovf_level", level0, 4);
        for (int i = 0; i < 4; i++) begin
            step0(1, 0, 0, 8'h00);
            chk("rd_dout", dout0, 32'h11 * (i + 1));
        end
        chk("rd_empty", empty0, 1);
        chk("ovf_sticky", ovf0, 1);
        chk("rd_unf", unf0, 0);
        step0(0, 0, 1, 8'h00);
        chk("flush_ovf", ovf0, 0);

        for (int i = 0; i < 10; i++) begin
            step0(0, 1, 0, 8'h10 + 8'(i));
            chk("wrap_lvl1", level0, 1);
            step0(1, 0, 0, 8'h00);
            chk("wrap_dout", dout0, 32'h10 + i);
            chk("wrap_lvl0", level0, 0);
        end
        chk("wrap_flags", {ovf0, unf0}, 0);

        step0(1, 1, 0, 8'h77);
        chk("rw_empty_lvl", level0, 1);
        chk("rw_empty_unf", unf0, 1);
        chk("rw_empty_dout", dout0, 8'h19);
        step0(1, 0, 0, 8'h00);
        chk("rw_empty_data", dout0, 8'h77);
        step0(0, 0, 1, 8'h00);
        chk("flush_unf", unf0, 0);
        for (int i = 0; i < 4; i++) step0(0, 1, 0, 8'hA0 + 8'(i));
        step0(1, 1, 0, 8'hB0);
        chk("rw_full_dout", dout0, 8'hA0);
        chk("rw_full_lvl", level0, 4);
        chk("rw_full_ovf", ovf0, 0);
        for (int i = 0; i < 4; i++) begin
            step0(1, 0, 0, 8'h00);
            chk("rw_full_seq", dout0, i == 3 ? 32'hB0 : 32'hA1 + i);
        end

        for (int i = 0; i < 5; i++) step0(0, 1, 0, 8'hC1 + 8'(i));
        step0(1, 0, 0, 8'h00);
        chk("pre_flush_dout", dout0, 8'hC1);
        chk("pre_flush_lvl", level0, 3);
        chk("pre_flush_ovf", ovf0, 1);
        step0(0, 1, 1, 8'hEE);
        chk("flush_lvl", level0, 0);
        chk("flush_empty", empty0, 1);
        chk("flush_flags", {ovf0, unf0}, 0);
        chk("flush_dout", dout0, 8'hC1);
        step0(1, 0, 0, 8'h00);
        chk("flush_drop_unf", unf0, 1);
        chk("flush_drop_dout", dout0, 8'hC1);

        wr1 = 1'b1;
        din1 = 8'h5A;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("edge_hold_w", level1, 0);
        end
        wr1 = 1'b0;
        tick();
        chk("edge_w_n", level1, 0);
        tick();
        chk("edge_w_n1", level1, 1);
        repeat (3) tick();
        chk("edge_w_once", level1, 1);
        rd1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("edge_hold_r", level1, 1);
        end
        chk("edge_hold_dout", dout1, 0);
        rd1 = 1'b0;
        tick();
        chk("edge_r_n", dout1, 0);
        tick();
        chk("edge_r_dout", dout1, 8'h5A);
        chk("edge_r_lvl", level1, 0);
        chk("edge_flags", {ovf1, unf1}, 0);

        step0(0, 1, 0, 8'hD1);
        step0(0, 1, 0, 8'hD2);
        step0(1, 0, 0, 8'h00);
        step0(0, 1, 0, 8'hD3);
        chk("pre_rst_lvl", level0, 2);
        #2 reset = 1'b1;
        #1;
        chk("arst_lvl", level0, 0);
        chk("arst_empty", empty0, 1);
        chk("arst_ae_af", {ae0, af0}, 2'b10);
        chk("arst_dout", dout0, 0);
        chk("arst_flags", {ovf0, unf0, full0}, 0);
        #3 reset = 1'b0;
        tick();
        chk("post_rst_lvl", level0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
